// File: rtl/data_memory_write_buffer.sv
// data_memory_write_buffer
//   Data-memory responder for a single-cycle datapath. Stores are posted into
//   an in-order write buffer and drained one at a time into a slow backing
//   word array (WRITE_LATENCY cycles per write). Reads are combinational and
//   forward from the youngest matching buffer entry, so they always return the
//   architecturally newest value.
//
// Ports
//   clk                       rising-edge clock
//   reset                     synchronous, active-high reset
//   data_memory_address       word address [31:2]; [ADDR_WIDTH+1:2] is the index
//   data_memory_write_enable  store request this cycle
//   data_memory_write_input   store data
//   data_memory_read_result   combinational read of the addressed word
//   data_memory_stall         store not accepted this cycle (buffer full)
//   write_buffer_empty        nothing pending and drain engine idle
module data_memory_write_buffer #(
  parameter int ADDR_WIDTH    = 10,
  parameter int BUFFER_DEPTH  = 4,
  parameter int WRITE_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] data_memory_address,
  input  logic        data_memory_write_enable,
  input  logic [31:0] data_memory_write_input,
  output logic [31:0] data_memory_read_result,
  output logic        data_memory_stall,
  output logic        write_buffer_empty
);

  localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
  localparam int LAT_W = (WRITE_LATENCY > 1) ? $clog2(WRITE_LATENCY) : 1;
  localparam int WORDS = 1 << ADDR_WIDTH;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(BUFFER_DEPTH);
  localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(WRITE_LATENCY - 1);
  localparam logic [PTR_W:0]   DEPTH_WIDE = (PTR_W + 1)'(BUFFER_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } drain_state_t;

  // Drain engine and buffer bookkeeping
  drain_state_t     state_q, state_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Buffer storage
  logic [ADDR_WIDTH-1:0]   ent_idx_q  [BUFFER_DEPTH];
  logic [31:0]             ent_data_q [BUFFER_DEPTH];
  logic [BUFFER_DEPTH-1:0] ent_valid_q;

  // Backing word array
  logic [31:0] backing_q [WORDS];

  logic [ADDR_WIDTH-1:0] idx_s;
  logic                  stall_s;
  logic                  push_s;
  logic                  pop_s;
  logic [31:0]           read_s;
  logic [PTR_W:0]        fwd_pos_s;
  logic                  unused_addr_s;

  // Wrap a buffer pointer at BUFFER_DEPTH (depth need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(BUFFER_DEPTH - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  // Upper address bits alias onto the same index and are intentionally dropped.
  assign unused_addr_s = ^data_memory_address[31:ADDR_WIDTH+2];

  assign idx_s   = data_memory_address[ADDR_WIDTH+1:2];
  // Stall looks only at the registered count; a pop on the same edge does not
  // free the slot early.
  assign stall_s = data_memory_write_enable && (count_q == FULL_COUNT);
  assign push_s  = data_memory_write_enable && !stall_s;
  assign pop_s   = (state_q == ST_BUSY) && (lat_cnt_q == '0);

  // Drain FSM next state: wait WRITE_LATENCY edges in BUSY, commit on the last.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          state_d   = ST_BUSY;
          lat_cnt_d = LAT_LOAD;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (lat_cnt_q != '0) begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end else begin
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        lat_cnt_d = '0;
      end
    endcase
  end

  // Pointer and occupancy next state; push and pop on one edge cancel in count.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_s) begin
      head_d = ptr_inc(head_q);
    end else begin
      head_d = head_q;
    end
    if (push_s) begin
      tail_d = ptr_inc(tail_q);
    end else begin
      tail_d = tail_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      lat_cnt_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Buffer entries: fill at tail on push, invalidate head on commit.
  // The full-buffer stall guarantees push and pop never target the same slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_valid_q <= '0;
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        ent_idx_q[i]  <= '0;
        ent_data_q[i] <= 32'h0000_0000;
      end
    end else begin
      if (pop_s) begin
        ent_valid_q[head_q] <= 1'b0;
      end
      if (push_s) begin
        ent_idx_q[tail_q]   <= idx_s;
        ent_data_q[tail_q]  <= data_memory_write_input;
        ent_valid_q[tail_q] <= 1'b1;
      end
    end
  end

  // Backing array: cleared on reset, written only by the head commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < WORDS; w++) begin
        backing_q[w] <= 32'h0000_0000;
      end
    end else if (pop_s) begin
      backing_q[ent_idx_q[head_q]] <= ent_data_q[head_q];
    end
  end

  // Forwarding read: walk the buffer oldest-to-youngest from head so the last
  // match is the youngest. The committing entry is still valid during its
  // commit cycle, so the read never dips to the stale backing value.
  always_comb begin
    read_s    = backing_q[idx_s];
    fwd_pos_s = '0;
    for (int i = 0; i < BUFFER_DEPTH; i++) begin
      fwd_pos_s = {1'b0, head_q} + (PTR_W + 1)'(i);
      if (fwd_pos_s >= DEPTH_WIDE) begin
        fwd_pos_s = fwd_pos_s - DEPTH_WIDE;
      end else begin
        fwd_pos_s = fwd_pos_s;
      end
      if (ent_valid_q[fwd_pos_s[PTR_W-1:0]] &&
          (ent_idx_q[fwd_pos_s[PTR_W-1:0]] == idx_s)) begin
        read_s = ent_data_q[fwd_pos_s[PTR_W-1:0]];
      end else begin
        read_s = read_s;
      end
    end
  end

  assign data_memory_read_result = read_s;
  assign data_memory_stall       = stall_s;
  assign write_buffer_empty      = (count_q == '0) && (state_q == ST_IDLE);

endmodule
